// File: rtl/deser_pkg.sv
// Shared types and width helpers for the bit deserializer slice.
package deser_pkg;

    // Default word width and the matching bit-counter width.
    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned CNT_W     = $clog2(DEF_WIDTH);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

    // Width needed to hold 0..depth inclusive.
    function automatic int unsigned fill_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    // Width of a counter running 0..width-1 (at least one bit).
    function automatic int unsigned cnt_w(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/bit_deserializer_if.sv
// Valid/ready word interface between the deserializer and the parallel datapath.
interface bit_deserializer_if #(
    parameter int unsigned WIDTH = 8
) ();

    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             word_ready;

    modport master (
        output word_out,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  word_out,
        input  word_valid,
        output word_ready
    );

endinterface

// File: rtl/bit_deserializer_sync_fifo.sv
// Small synchronous FIFO with push/pop, full/empty flags and an occupancy count.
// A push while full is accepted only when a pop frees the head slot on the same edge.
module sync_fifo
    import deser_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [fill_w(DEPTH)-1:0]   count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = fill_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    // Head comes straight from storage; forced to zero when nothing is held.
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // Qualify push/pop against the current occupancy.
    always_comb begin
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
    end

    // Storage, pointers (wrap naturally since DEPTH is a power of two) and count.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/bit_deserializer.sv
// Serial-to-parallel converter: undoes the upstream inversion, packs bits into
// WIDTH-bit words and buffers them in a FIFO behind a valid/ready interface.
module bit_deserializer
    import deser_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 2,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          INVERT_IN = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bit_in,
    input  logic                     bit_valid,
    bit_deserializer_if.master       out_if,
    output logic                     overflow,
    input  logic                     overflow_clr,
    output logic [fill_w(DEPTH)-1:0] fill_level,
    output logic                     busy
);

    localparam int unsigned CntW = cnt_w(WIDTH);

    state_e           state_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic             overflow_q;
    logic             eff_bit;
    logic             word_done;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             drop;

    // Next shift-register value and word-completion / drop decisions.
    always_comb begin
        eff_bit = bit_in ^ INVERT_IN;
        if (MSB_FIRST) begin
            sr_d = {sr_q[WIDTH-2:0], eff_bit};
        end else begin
            sr_d = {eff_bit, sr_q[WIDTH-1:1]};
        end
        word_done = bit_valid && (cnt_q == CntW'(WIDTH - 1));
        pop       = !fifo_empty && out_if.word_ready;
        // A full FIFO only accepts the new word if the head leaves on this edge.
        drop      = word_done && fifo_full && !pop;
    end

    // Accumulation FSM, bit counter, shifter and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sr_q       <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (bit_valid) begin
                sr_q <= sr_d;
                if (word_done) begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end else begin
                    cnt_q   <= cnt_q + CntW'(1);
                    state_q <= ACCUM;
                end
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (overflow_clr) begin
                overflow_q <= 1'b0;
            end
        end
    end

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (word_done),
        .wdata_i (sr_d),
        .pop_i   (out_if.word_ready),
        .rdata_o (out_if.word_out),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fill_level)
    );

    assign out_if.word_valid = !fifo_empty;
    assign overflow          = overflow_q;
    assign busy              = (state_q == ACCUM);

endmodule

// File: tb/tb_bit_deserializer.sv
// Randomised bench for bit_deserializer: two instances (MSB-first/inverting and
// LSB-first/pass-through) share one stimulus stream and are compared every
// cycle against a word-level queue model.
module tb_bit_deserializer;
    import deser_pkg::*;

    localparam int unsigned W  = 8;
    localparam int unsigned D  = 2;
    localparam int unsigned FW = fill_w(D);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          bit_in = 1'b0;
    logic          bit_valid = 1'b0;
    logic          word_ready = 1'b0;
    logic          overflow_clr = 1'b0;
    logic          ovf_a, ovf_b, busy_a, busy_b;
    logic [FW-1:0] fill_a, fill_b;

    bit_deserializer_if #(.WIDTH(W)) if_a ();
    bit_deserializer_if #(.WIDTH(W)) if_b ();
    assign if_a.word_ready = word_ready;
    assign if_b.word_ready = word_ready;

    bit_deserializer #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1'b1), .INVERT_IN(1'b1)) dut_a (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .out_if(if_a),
        .overflow(ovf_a), .overflow_clr(overflow_clr), .fill_level(fill_a), .busy(busy_a)
    );

    bit_deserializer #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1'b0), .INVERT_IN(1'b0)) dut_b (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .out_if(if_b),
        .overflow(ovf_b), .overflow_clr(overflow_clr), .fill_level(fill_b), .busy(busy_b)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: index 0 = MSB-first inverting, 1 = LSB-first pass-through.
    bit         m_bits [2][W];
    int         m_bcnt [2];
    logic [W-1:0] m_fq [2][D];
    int         m_fcnt [2];
    bit         m_ovf  [2];

    task automatic model_step(input bit b, input bit v, input bit r, input bit c, input bit rs);
        for (int k = 0; k < 2; k++) begin
            bit           pop;
            bit           drop;
            logic [W-1:0] word;
            if (rs) begin
                m_bcnt[k] = 0;
                m_fcnt[k] = 0;
                m_ovf[k]  = 1'b0;
            end else begin
                pop  = (m_fcnt[k] > 0) && r;
                drop = 1'b0;
                if (pop) begin
                    for (int i = 0; i < int'(D) - 1; i++) m_fq[k][i] = m_fq[k][i+1];
                    m_fcnt[k]--;
                end
                if (v) begin
                    m_bits[k][m_bcnt[k]] = (k == 0) ? ~b : b;
                    m_bcnt[k]++;
                    if (m_bcnt[k] == int'(W)) begin
                        word = '0;
                        for (int i = 0; i < int'(W); i++) begin
                            if (k == 0) word[int'(W) - 1 - i] = m_bits[k][i];
                            else        word[i] = m_bits[k][i];
                        end
                        m_bcnt[k] = 0;
                        if (m_fcnt[k] < int'(D)) begin
                            m_fq[k][m_fcnt[k]] = word;
                            m_fcnt[k]++;
                        end else begin
                            drop = 1'b1;
                        end
                    end
                end
                if (c)    m_ovf[k] = 1'b0;
                if (drop) m_ovf[k] = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        check("a.valid", {31'd0, if_a.word_valid}, {31'd0, m_fcnt[0] != 0});
        check("a.word", {24'd0, if_a.word_out}, (m_fcnt[0] != 0) ? {24'd0, m_fq[0][0]} : 32'd0);
        check("a.fill", {30'd0, fill_a}, m_fcnt[0]);
        check("a.ovf", {31'd0, ovf_a}, {31'd0, m_ovf[0]});
        check("a.busy", {31'd0, busy_a}, {31'd0, m_bcnt[0] != 0});
        check("b.valid", {31'd0, if_b.word_valid}, {31'd0, m_fcnt[1] != 0});
        check("b.word", {24'd0, if_b.word_out}, (m_fcnt[1] != 0) ? {24'd0, m_fq[1][0]} : 32'd0);
        check("b.fill", {30'd0, fill_b}, m_fcnt[1]);
        check("b.ovf", {31'd0, ovf_b}, {31'd0, m_ovf[1]});
        check("b.busy", {31'd0, busy_b}, {31'd0, m_bcnt[1] != 0});
    endtask

    // Apply one cycle of inputs, advance the model across the edge, then compare.
    task automatic step(input bit b, input bit v, input bit r, input bit c, input bit rs);
        bit_in       = b;
        bit_valid    = v;
        word_ready   = r;
        overflow_clr = c;
        rst          = rs;
        @(posedge clk);
        model_step(b, v, r, c, rs);
        #1;
        compare_all();
    endtask

    // Send a word as raw line bits, first bit = raw[7].
    task automatic send_raw(input logic [7:0] raw, input bit r);
        for (int i = 7; i >= 0; i--) step(raw[i], 1'b1, r, 1'b0, 1'b0);
    endtask

    initial begin
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("rst.valid", {31'd0, if_a.word_valid}, 32'd0);

        // Bits 0,1,0,1,1,0,1,0 -> A5 (invert, MSB first) and 5A (raw, LSB first).
        send_raw(8'h5A, 1'b1);
        check("t1.a", {24'd0, if_a.word_out}, 32'h0000_00A5);
        check("t2.b", {24'd0, if_b.word_out}, 32'h0000_005A);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t1.pulse", {31'd0, if_a.word_valid}, 32'd0);

        // Stall: third word overflows a two-entry FIFO.
        send_raw(~8'h01, 1'b0);
        check("t3.fill1", {30'd0, fill_a}, 32'd1);
        send_raw(~8'h02, 1'b0);
        check("t3.fill2", {30'd0, fill_a}, 32'd2);
        send_raw(~8'h03, 1'b0);
        check("t3.ovf", {31'd0, ovf_a}, 32'd1);
        check("t3.head1", {24'd0, if_a.word_out}, 32'h01);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t3.head2", {24'd0, if_a.word_out}, 32'h02);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t3.empty", {31'd0, if_a.word_valid}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t3.clr", {31'd0, ovf_a}, 32'd0);

        // Third word completes on the same edge as a pop.
        send_raw(~8'h11, 1'b0);
        send_raw(~8'h22, 1'b0);
        for (int i = 7; i >= 1; i--) step(~8'h33 >> i, 1'b1, 1'b0, 1'b0, 1'b0);
        step(~8'h33 & 8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
        check("t4.ovf", {31'd0, ovf_a}, 32'd0);
        check("t4.fill", {30'd0, fill_a}, 32'd2);
        check("t4.head2", {24'd0, if_a.word_out}, 32'h22);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t4.head3", {24'd0, if_a.word_out}, 32'h33);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Gap in the middle of a word.
        for (int i = 7; i >= 4; i--) step(~8'hC3 >> i, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'($urandom), 1'b0, 1'b1, 1'b0, 1'b0);
            check("t5.busy", {31'd0, busy_a}, 32'd1);
        end
        for (int i = 3; i >= 0; i--) step(~8'hC3 >> i, 1'b1, 1'b1, 1'b0, 1'b0);
        check("t5.word", {24'd0, if_a.word_out}, 32'hC3);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of a word discards it.
        for (int i = 0; i < 5; i++) step(1'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        check("t6.valid", {31'd0, if_a.word_valid}, 32'd0);
        check("t6.word", {24'd0, if_a.word_out}, 32'd0);
        check("t6.fill", {30'd0, fill_a}, 32'd0);
        check("t6.busy", {31'd0, busy_a}, 32'd0);
        check("t6.ovf", {31'd0, ovf_a}, 32'd0);
        send_raw(~8'h96, 1'b0);
        check("t6.fresh", {24'd0, if_a.word_out}, 32'h96);
        check("t6.fill1", {30'd0, fill_a}, 32'd1);

        // Random traffic with varying consumer pressure.
        for (int ph = 0; ph < 6; ph++) begin
            int unsigned rdy_pct;
            rdy_pct = (ph % 3 == 0) ? 10 : ((ph % 3 == 1) ? 50 : 95);
            for (int i = 0; i < 600; i++) begin
                step(1'($urandom),
                     ($urandom_range(0, 99) < 75),
                     ($urandom_range(0, 99) < rdy_pct),
                     ($urandom_range(0, 99) < 4),
                     ($urandom_range(0, 999) < 3));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bit_deserializer.md
Name: bit_deserializer

Overview:
Downstream consumer of the registered serial inverter stage. Samples its one-bit-per-clock output and can undo the inversion. Packs bits into WIDTH-bit words and buffers them in a small FIFO. Presents words on a valid/ready interface to the parallel datapath, with overflow detection when the consumer stalls.

Parameters:
WIDTH, 8, bits per assembled word (2..32)
DEPTH, 2, output FIFO entries (power of two, 2..8)
MSB_FIRST, 1, 1: first received bit lands in word_out[WIDTH-1]; 0: first bit lands in word_out[0]
INVERT_IN, 1, 1: each bit is complemented before packing (restores pre-inverter polarity); 0: bits pass through unchanged

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous reset, active-high
bit_in  in  1  serial data from the upstream inverter stage
bit_valid  in  1  bit_in is sampled on edges where this is high
word_out  out  WIDTH  FIFO head word
word_valid  out  1  FIFO non-empty
word_ready  in  1  consumer accepts the head word on this edge
overflow  out  1  sticky: a completed word was dropped because the FIFO was full
overflow_clr  in  1  clears overflow
fill_level  out  $clog2(DEPTH)+1  number of words currently held in the FIFO
busy  out  1  a partial word is in progress (bit count != 0)

Behaviour:
- Reset: every state change happens on rising clk. While rst is high at an edge:
  - bit count = 0, shift register = 0, FIFO emptied.
  - word_valid=0, word_out=0, overflow=0, fill_level=0, busy=0.
  - A partial word in progress is discarded; bit_valid is ignored during reset.
- Bit handling:
  - Effective bit b = bit_in XOR INVERT_IN.
  - MSB_FIRST=1: shift left, inserting b at the LSB.
  - MSB_FIRST=0: shift right, inserting b at the MSB.
- Counter:
  - 0..WIDTH-1; increments on each edge with bit_valid=1.
  - Gaps (bit_valid=0) hold all state indefinitely; there is no timeout.
- State machine:
  - IDLE (count==0) -> ACCUM on the first valid bit.
  - ACCUM -> IDLE on the edge that takes the WIDTH-th bit (count==WIDTH-1 and bit_valid).
- Word completion:
  - On that edge, the word including the current bit is pushed into the FIFO and the counter wraps to 0.
  - The next bit on the following edge starts a new word, so back-to-back words need no idle cycle.
- Latency: last bit sampled at edge N -> word_valid=1 and word_out valid after edge N, when the FIFO was empty.
- FIFO:
  - word_out is the head entry, registered from storage (no combinational path from bit_in).
  - A pop occurs when word_valid && word_ready.
  - word_ready while empty has no effect.
  - word_out holds its value while word_valid && !word_ready.
- Full with a simultaneous pop: the push succeeds and fill_level stays at DEPTH.
- Full without a pop:
  - The completed word is dropped, the FIFO is unchanged and overflow is set.
  - The counter still wraps to 0.
- Empty with a simultaneous push: no pop, since word_valid was 0 on that edge.
- overflow:
  - Set by a drop; cleared by overflow_clr.
  - If both happen on the same edge, set wins.
- Pointers wrap modulo DEPTH.
- fill_level changes:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on both or neither.

Decomposition:
- Shared package deser_pkg:
  - Localparam CNT_W = $clog2(WIDTH).
  - State enum {IDLE, ACCUM}.
  - Function for the fill_level width.
- One natural sub-module: sync_fifo (WIDTH, DEPTH) with push/pop/full/empty/count, reusable elsewhere.
- bit_deserializer keeps the shifter, counter, FSM and overflow logic.

Test Plan:
1. WIDTH=8, MSB_FIRST=1, INVERT_IN=1, word_ready=1: bit_in 0,1,0,1,1,0,1,0 on 8 consecutive edges -> word_out=8'hA5, word_valid high for exactly 1 cycle after the 8th edge.
2. Same bits with MSB_FIRST=0, INVERT_IN=0 -> word_out=8'h5A.
3. word_ready=0, DEPTH=2: stream 3 words 8'h01, 8'h02, 8'h03 (pre-inversion values) -> fill_level 1 then 2, overflow=1 after the 3rd word. Then raise word_ready -> reads 8'h01, 8'h02, FIFO empty; pulse overflow_clr -> overflow=0.
4. FIFO full, 3rd word completes on the same edge as a pop -> no overflow, fill_level stays 2, order is word1, word2, word3.
5. 4 valid bits, then 10 idle cycles, then 4 bits -> one correct word; busy=1 during the gap.
6. rst asserted after 5 bits, then 8 fresh bits -> only the fresh word appears; all outputs 0 in the cycle after reset.
